door_manager: RTL and testbench
===============================

DOOR_MANAGER -- requirements
Module: door_manager

Interface
REQ-001 Parameter DOORS, 4, doors per stage; power of two, 2..16.
REQ-002 Parameter STAGE_W, 5, stage code width.
REQ-003 Parameter CW, 16, world/screen pixel coordinate width; tiles are 32 px (coordinate bits [CW-1:5]).
REQ-004 Parameter COOLDOWN, 30, frames after an acknowledged transition during which no new request is raised.
REQ-005 Port clk  in  1  single system clock; all logic rising-edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port stageCode  in  STAGE_W  current stage.
REQ-008 Port frame_start  in  1  one-cycle pulse per video frame.
REQ-009 Port stage_posX, stage_posY  in  CW each  world scroll offset, px.
REQ-010 Port CounterX, CounterY  in  CW each  current screen pixel.
REQ-011 Port char_x0, char_x1, char_y0, char_y1  in  CW each  character hitbox, world px, inclusive.
REQ-012 Port rom_addr  out  STAGE_W+log2(DOORS)  door ROM address = {stageCode, idx}.
REQ-013 Port rom_data  in  26  entry, valid one cycle after rom_addr: [4:0] door tile X, [9:5] bottom tile Y (exclusive), [14:10] height (tiles), [19:15] next stage, [24:20] arrival tile X, [25] enable.
REQ-014 Port drawAny  out  1  current pixel lies in an enabled door.
REQ-015 Port trans_req  out  1  transition request; trans_ack  in  1  acceptance.
REQ-016 Port newStageCode  out  5, real_new_posX  out  CW  transition target (arrival X = tile*32).
REQ-017 Port hit_idx  out  log2(DOORS)  door index of pending/last request; scan_busy  out  1.

Function
REQ-018 FSM states IDLE, FETCH, CAPTURE, EVAL, REQ, COOL.
REQ-019 IDLE: on frame_start -> FETCH with idx=0, scan_busy=1.
REQ-020 FETCH drives rom_addr={stageCode,idx}; CAPTURE stores rom_data in cache[idx] the next cycle; idx increments; after idx=DOORS-1 -> EVAL; a full scan takes exactly 2*DOORS cycles.
REQ-021 frame_start during FETCH/CAPTURE/EVAL/REQ is ignored.
REQ-022 stageCode change (compared to a registered copy) in any state: all cache enable bits clear next cycle; FETCH/CAPTURE restart at idx=0; REQ is not affected.
REQ-023 Door world rectangle: x in [X*32, X*32+31], y in [(Y-H)*32, Y*32-1]; H=0 or enable=0 means no door; Y-H computed 6-bit, underflow (H>Y) clamps bottom-of-range to 0.
REQ-024 EVAL (1 cycle): door hits when door_x0<=char_x0, char_x1<=door_x1, door_y0<=char_y0, char_y1<=door_y1; lowest hit index wins -> REQ; no hit -> IDLE.
REQ-025 REQ: trans_req=1; newStageCode, real_new_posX, hit_idx registered on entry and held stable until trans_ack; trans_ack sampled high -> COOL with counter=COOLDOWN, trans_req low the following cycle.
REQ-026 trans_ack outside REQ is ignored.
REQ-027 COOL: counter decrements on each frame_start and scans still run (cache refresh) but EVAL never enters REQ; counter 0 -> IDLE; COOLDOWN=0 -> IDLE directly.
REQ-028 drawAny: world pixel = Counter + stage_pos (CW-bit, wrap-around); drawAny registered, one-cycle latency, = OR over doors of (tileX==X && (Y-H) <= tileY < Y && enable && H!=0), uses cache only, independent of FSM state.
REQ-029 Coordinate compares unsigned CW-bit; door pixel bounds formed as CW-bit values.

Reset
REQ-030 rst_n low asynchronously: state IDLE, idx 0, cache cleared (enable 0), cooldown 0, trans_req 0, drawAny 0, scan_busy 0, newStageCode 0, real_new_posX 0, hit_idx 0, rom_addr 0.
REQ-031 Reset released mid-scan or mid-REQ: no request survives; first frame_start after release starts a fresh scan.

Verification
REQ-032 DOORS=4, stage 1, door0 {X=31,Y=12,H=4,next=2,arrX=1,en=1}, char x 996..1000, y 288..380, frame_start -> scan 8 cycles, trans_req=1, newStageCode=2, real_new_posX=32, hit_idx=0.
REQ-033 Doors 1 and 3 both contain char -> hit_idx=1; hold trans_ack low 50 cycles -> outputs unchanged; ack -> trans_req low next cycle; no new request for 30 frame_start pulses, request on 31st.
REQ-034 stage_posX=64, CounterX=928, CounterY=320, door {X=31,Y=12,H=4} -> drawAny=1 one cycle later; CounterY=384 -> 0; H=0 -> 0.
REQ-035 stageCode 1->2 at scan idx 2 -> cache cleared, rescan from idx 0 with rom_addr {2,0}; stage-1 doors no longer drawn.
REQ-036 rst_n low during REQ -> trans_req 0 immediately (asynchronous), drawAny 0, cache empty until next scan.

Source files
------------

// File: rtl/door_manager_if.sv
// rtl/door_manager_if.sv - door ROM fetch bus and stage-transition handshake
//
// Purpose: groups the door ROM port and the transition request/acknowledge
//          handshake of door_manager into one bundle.
// Signals:
//   rom_addr       door ROM address {stageCode, idx}      (master -> slave)
//   rom_data       26-bit door entry, one cycle after addr  (slave -> master)
//   trans_req      transition request                      (master -> slave)
//   trans_ack      transition acceptance                   (slave -> master)
//   newStageCode   target stage of the pending request     (master -> slave)
//   real_new_posX  arrival X in world pixels               (master -> slave)
//   hit_idx        door index of the pending/last request  (master -> slave)
interface door_manager_if #(
    parameter int DOORS   = 4,
    parameter int STAGE_W = 5,
    parameter int CW      = 16
);
    localparam int IW = (DOORS > 1) ? $clog2(DOORS) : 1;

    logic [STAGE_W+IW-1:0] rom_addr;
    logic [25:0]           rom_data;
    logic                  trans_req;
    logic                  trans_ack;
    logic [4:0]            newStageCode;
    logic [CW-1:0]         real_new_posX;
    logic [IW-1:0]         hit_idx;

    modport master (
        output rom_addr,
        input  rom_data,
        output trans_req,
        input  trans_ack,
        output newStageCode,
        output real_new_posX,
        output hit_idx
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  trans_req,
        output trans_ack,
        input  newStageCode,
        input  real_new_posX,
        input  hit_idx
    );
endinterface

// File: rtl/door_manager.sv
// rtl/door_manager.sv - per-frame door scan, door drawing and stage transition requests
//
// Purpose: once per video frame reads every door of the current stage from the
//          door ROM into a local cache, checks whether the character hitbox lies
//          fully inside one of the doors and, if so, raises a transition request
//          that is held until acknowledged, followed by a cooldown measured in
//          frames. In parallel it flags screen pixels that fall on a cached door.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stageCode                  current stage
//   frame_start                one-cycle pulse per frame, starts a scan
//   stage_posX/Y               world scroll offset (px)
//   CounterX/Y                 current screen pixel
//   char_x0/x1/y0/y1           character hitbox, world px, inclusive
//   bus (master)               door ROM port and transition handshake
//   drawAny                    registered: current pixel lies in an enabled door
//   scan_busy                  ROM scan in progress
module door_manager #(
    parameter int DOORS    = 4,
    parameter int STAGE_W  = 5,
    parameter int CW       = 16,
    parameter int COOLDOWN = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STAGE_W-1:0] stageCode,
    input  logic               frame_start,
    input  logic [CW-1:0]      stage_posX,
    input  logic [CW-1:0]      stage_posY,
    input  logic [CW-1:0]      CounterX,
    input  logic [CW-1:0]      CounterY,
    input  logic [CW-1:0]      char_x0,
    input  logic [CW-1:0]      char_x1,
    input  logic [CW-1:0]      char_y0,
    input  logic [CW-1:0]      char_y1,
    door_manager_if.master     bus,
    output logic               drawAny,
    output logic               scan_busy
);
    localparam int IW    = (DOORS > 1) ? $clog2(DOORS) : 1;
    localparam int TW    = CW - 5;
    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [IW-1:0]    LAST_IDX  = IW'(DOORS - 1);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EVAL,
        REQ,
        COOL
    } state_t;

    state_t             state, stateNext;
    logic [IW-1:0]      idx, idxNext;
    logic [CNT_W-1:0]   coolCnt;
    logic               coolScan;
    logic [STAGE_W-1:0] stageReg;
    logic [25:0]        cache [DOORS];

    logic stageChg;
    logic startScan;
    logic doCapture;
    logic loadReq;
    logic loadCool;
    logic decCool;

    // Door geometry decoded from the cache
    logic [4:0]       dX   [DOORS];
    logic [4:0]       dY   [DOORS];
    logic [4:0]       dH   [DOORS];
    logic [4:0]       dLo  [DOORS];
    logic [5:0]       yDiff[DOORS];
    logic [CW-1:0]    dx0  [DOORS];
    logic [CW-1:0]    dx1  [DOORS];
    logic [CW-1:0]    dy0  [DOORS];
    logic [CW-1:0]    dy1  [DOORS];
    logic [DOORS-1:0] dOn;

    logic          anyHit;
    logic [IW-1:0] hitSel;

    logic [CW-1:0] worldX, worldY;
    logic [TW-1:0] tileX, tileY;
    logic          drawNext;

    assign stageChg = (stageCode != stageReg);

    always_comb begin
        for (int i = 0; i < DOORS; i++) begin
            dX[i]    = cache[i][4:0];
            dY[i]    = cache[i][9:5];
            dH[i]    = cache[i][14:10];
            // Top tile row; a door taller than its bottom row clamps to row 0
            yDiff[i] = {1'b0, dY[i]} - {1'b0, dH[i]};
            dLo[i]   = yDiff[i][5] ? 5'd0 : yDiff[i][4:0];
            dOn[i]   = cache[i][25] && (dH[i] != 5'd0);
            dx0[i]   = CW'({dX[i], 5'b00000});
            dx1[i]   = dx0[i] | CW'(31);
            dy0[i]   = CW'({dLo[i], 5'b00000});
            dy1[i]   = CW'({dY[i], 5'b00000}) - CW'(1);
        end
    end

    // Lowest-index door fully containing the character wins
    always_comb begin
        anyHit = 1'b0;
        hitSel = '0;
        for (int i = DOORS - 1; i >= 0; i--) begin
            if (dOn[i] && (dx0[i] <= char_x0) && (char_x1 <= dx1[i]) &&
                (dy0[i] <= char_y0) && (char_y1 <= dy1[i])) begin
                anyHit = 1'b1;
                hitSel = IW'(i);
            end
        end
    end

    // Pixel-to-tile lookup against the cache; world coordinates wrap at CW bits
    assign worldX = CounterX + stage_posX;
    assign worldY = CounterY + stage_posY;
    assign tileX  = worldX[CW-1:5];
    assign tileY  = worldY[CW-1:5];

    always_comb begin
        drawNext = 1'b0;
        for (int i = 0; i < DOORS; i++) begin
            if (dOn[i] && (tileX == TW'(dX[i])) &&
                (tileY >= TW'(dLo[i])) && (tileY < TW'(dY[i]))) begin
                drawNext = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        startScan = 1'b0;
        doCapture = 1'b0;
        loadReq   = 1'b0;
        loadCool  = 1'b0;
        decCool   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    stateNext = FETCH;
                    idxNext   = '0;
                    startScan = 1'b1;
                end
            end
            FETCH: begin
                stateNext = CAPTURE;
            end
            CAPTURE: begin
                doCapture = 1'b1;
                if (idx == LAST_IDX) begin
                    stateNext = EVAL;
                end else begin
                    stateNext = FETCH;
                    idxNext   = idx + IW'(1);
                end
            end
            EVAL: begin
                // Scans launched during cooldown only refresh the cache
                if (anyHit && !coolScan) begin
                    stateNext = REQ;
                    loadReq   = 1'b1;
                end else if (coolCnt != '0) begin
                    stateNext = COOL;
                end else begin
                    stateNext = IDLE;
                end
            end
            REQ: begin
                if (bus.trans_ack) begin
                    loadCool  = 1'b1;
                    stateNext = (COOLDOWN == 0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (coolCnt == '0) begin
                    stateNext = IDLE;
                end else if (frame_start) begin
                    decCool   = 1'b1;
                    stateNext = FETCH;
                    idxNext   = '0;
                    startScan = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // A stage switch invalidates a scan in flight: start over from door 0
        if (stageChg && ((state == FETCH) || (state == CAPTURE))) begin
            stateNext = FETCH;
            idxNext   = '0;
            doCapture = 1'b0;
        end
    end

    assign bus.trans_req = (state == REQ);
    assign scan_busy     = (state == FETCH) || (state == CAPTURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx               <= '0;
            coolCnt           <= '0;
            coolScan          <= 1'b0;
            stageReg          <= '0;
            drawAny           <= 1'b0;
            bus.rom_addr      <= '0;
            bus.newStageCode  <= '0;
            bus.real_new_posX <= '0;
            bus.hit_idx       <= '0;
        end else begin
            idx      <= idxNext;
            stageReg <= stageCode;
            drawAny  <= drawNext;
            // Address is registered so the ROM sees it for the whole FETCH cycle
            if (stateNext == FETCH) begin
                bus.rom_addr <= {stageCode, idxNext};
            end
            if (startScan) begin
                coolScan <= (state == COOL);
            end
            if (loadCool) begin
                coolCnt <= COOL_INIT;
            end else if (decCool) begin
                coolCnt <= coolCnt - CNT_W'(1);
            end
            if (loadReq) begin
                bus.newStageCode  <= cache[hitSel][19:15];
                bus.real_new_posX <= CW'({cache[hitSel][24:20], 5'b00000});
                bus.hit_idx       <= hitSel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DOORS; i++) begin
                cache[i] <= '0;
            end
        end else if (stageChg) begin
            for (int i = 0; i < DOORS; i++) begin
                cache[i][25] <= 1'b0;
            end
        end else if (doCapture) begin
            cache[idx] <= bus.rom_data;
        end
    end
endmodule

// File: tb/tb_door_manager.sv
// tb/tb_door_manager.sv - scoreboard testbench for door_manager
module tb_door_manager;
    localparam int DOORS    = 4;
    localparam int STAGE_W  = 5;
    localparam int CW       = 16;
    localparam int COOLDOWN = 30;

    logic          clk;
    logic          rst_n;
    logic [4:0]    stageCode;
    logic          frame_start;
    logic [CW-1:0] stage_posX, stage_posY, CounterX, CounterY;
    logic [CW-1:0] char_x0, char_x1, char_y0, char_y1;
    logic          drawAny;
    logic          scan_busy;

    door_manager_if #(.DOORS(DOORS), .STAGE_W(STAGE_W), .CW(CW)) bus ();

    door_manager #(
        .DOORS(DOORS), .STAGE_W(STAGE_W), .CW(CW), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stageCode  (stageCode),
        .frame_start(frame_start),
        .stage_posX (stage_posX),
        .stage_posY (stage_posY),
        .CounterX   (CounterX),
        .CounterY   (CounterY),
        .char_x0    (char_x0),
        .char_x1    (char_x1),
        .char_y0    (char_y0),
        .char_y1    (char_y1),
        .bus        (bus),
        .drawAny    (drawAny),
        .scan_busy  (scan_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous door ROM: [stage][door]
    logic [25:0] rom [32][DOORS];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[6:2]][bus.rom_addr[1:0]];

    typedef struct {
        bit         req;
        int         len;
        logic [4:0] ns;
        logic [15:0] px;
        logic [1:0] idx;
    } exp_t;

    exp_t        expQ[$];
    exp_t        lastExp;
    int          nTests;
    int          nFail;
    int          modelCool;
    bit          mdlValid;
    logic [25:0] mdlCache [DOORS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] mk(input int en, input int arr, input int nxt,
                                       input int h, input int y, input int x);
        logic [25:0] r;
        r[25]    = (en != 0);
        r[24:20] = arr[4:0];
        r[19:15] = nxt[4:0];
        r[14:10] = h[4:0];
        r[9:5]   = y[4:0];
        r[4:0]   = x[4:0];
        return r;
    endfunction

    // Reference: door rectangles in plain integer pixel arithmetic
    task automatic modelHit(input int st, output bit hit, output int hidx);
        hit  = 0;
        hidx = 0;
        for (int i = 0; i < DOORS; i++) begin
            logic [25:0] e;
            int x, y, h, lo, x0, x1, y0, y1;
            e  = rom[st][i];
            x  = int'(e[4:0]);
            y  = int'(e[9:5]);
            h  = int'(e[14:10]);
            lo = (y >= h) ? y - h : 0;
            x0 = x * 32;
            x1 = x0 + 31;
            y0 = lo * 32;
            y1 = (y * 32 - 1) & 32'hFFFF;
            if (!hit && e[25] && h != 0 &&
                x0 <= int'(char_x0) && int'(char_x1) <= x1 &&
                y0 <= int'(char_y0) && int'(char_y1) <= y1) begin
                hit  = 1;
                hidx = i;
            end
        end
    endtask

    function automatic bit modelDraw();
        int wx, wy, tx, ty;
        bit r;
        r  = 0;
        wx = (int'(CounterX) + int'(stage_posX)) & 32'hFFFF;
        wy = (int'(CounterY) + int'(stage_posY)) & 32'hFFFF;
        tx = wx / 32;
        ty = wy / 32;
        if (mdlValid) begin
            for (int i = 0; i < DOORS; i++) begin
                int x, y, h, lo;
                x  = int'(mdlCache[i][4:0]);
                y  = int'(mdlCache[i][9:5]);
                h  = int'(mdlCache[i][14:10]);
                lo = (y >= h) ? y - h : 0;
                if (mdlCache[i][25] && h != 0 && tx == x && ty >= lo && ty < y) r = 1;
            end
        end
        return r;
    endfunction

    task automatic predict(input int st, input int len, output exp_t e);
        bit h;
        int hi;
        bit blocked;
        modelHit(st, h, hi);
        blocked = (modelCool > 0);
        if (blocked) modelCool--;
        e.req = h && !blocked;
        e.len = len;
        e.ns  = rom[st][hi][19:15];
        e.px  = 16'(int'(rom[st][hi][24:20]) * 32);
        e.idx = 2'(hi);
    endtask

    task automatic waitSb();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL sb_timeout: %0d responses outstanding, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic pulseFrame();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic loadCacheModel(input int st);
        for (int i = 0; i < DOORS; i++) mdlCache[i] = rom[st][i];
        mdlValid = 1;
    endtask

    task automatic frame(input bit extra);
        exp_t e;
        predict(int'(stageCode), 2 * DOORS, e);
        expQ.push_back(e);
        lastExp = e;
        pulseFrame();
        if (extra) begin
            repeat (3) @(posedge clk);
            #1 frame_start = 1'b1;
            @(posedge clk);
            #1 frame_start = 1'b0;
        end
        waitSb();
        loadCacheModel(int'(stageCode));
    endtask

    task automatic ackReq(input int dly);
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        check("req_hold", bus.trans_req, 1);
        check("hold_idx", bus.hit_idx, lastExp.idx);
        check("hold_stage", bus.newStageCode, lastExp.ns);
        check("hold_posx", bus.real_new_posX, lastExp.px);
        bus.trans_ack = 1'b1;
        @(posedge clk);
        #1 bus.trans_ack = 1'b0;
        check("req_drop", bus.trans_req, 0);
        modelCool = COOLDOWN;
    endtask

    task automatic drain();
        while (modelCool > 0) frame(0);
    endtask

    task automatic drawCheck(input string name, input int cx, input int cy,
                             input int px, input int py);
        CounterX   = 16'(cx);
        CounterY   = 16'(cy);
        stage_posX = 16'(px);
        stage_posY = 16'(py);
        @(posedge clk);
        #1 check(name, drawAny, modelDraw());
    endtask

    task automatic setStage(input int st);
        if (5'(st) != stageCode) mdlValid = 0;
        stageCode = 5'(st);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic setChar(input int x0, input int x1, input int y0, input int y1);
        char_x0 = 16'(x0);
        char_x1 = 16'(x1);
        char_y0 = 16'(y0);
        char_y1 = 16'(y1);
    endtask

    // Monitor: measures every scan and compares the outcome one cycle after it ends
    initial begin : monitor
        int   runLen;
        bit   prevBusy;
        exp_t e;
        runLen   = 0;
        prevBusy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                runLen   = 0;
                prevBusy = 0;
            end else begin
                if (scan_busy) begin
                    runLen++;
                end else if (prevBusy) begin
                    @(negedge clk);
                    nTests++;
                    if (expQ.size() == 0) begin
                        nFail++;
                        $display("FAIL unexpected_scan: scan of %0d cycles, expected none", runLen);
                    end else begin
                        e = expQ.pop_front();
                        check("scan_len", runLen, e.len);
                        check("trans_req", bus.trans_req, e.req);
                        if (e.req) begin
                            check("newStageCode", bus.newStageCode, e.ns);
                            check("real_new_posX", bus.real_new_posX, e.px);
                            check("hit_idx", bus.hit_idx, e.idx);
                        end
                    end
                    runLen = 0;
                end
                prevBusy = scan_busy;
            end
        end
    end

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int   n, st, t, x, y, h, lo, wx, wy, ty, px, py;
        exp_t e;
        nTests = 0;
        nFail = 0;
        modelCool = 0;
        mdlValid = 0;
        for (int s = 0; s < 32; s++)
            for (int i = 0; i < DOORS; i++) rom[s][i] = '0;
        rst_n = 1'b0;
        stageCode = 5'd0;
        frame_start = 1'b0;
        bus.trans_ack = 1'b0;
        stage_posX = '0; stage_posY = '0; CounterX = '0; CounterY = '0;
        setChar(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_trans_req", bus.trans_req, 0);
        check("rst_drawAny", drawAny, 0);
        check("rst_scan_busy", scan_busy, 0);
        check("rst_newStageCode", bus.newStageCode, 0);
        check("rst_real_new_posX", bus.real_new_posX, 0);
        check("rst_hit_idx", bus.hit_idx, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        rst_n = 1'b1;

        // Single door on stage 1 containing the character
        rom[1][0] = mk(1, 1, 2, 4, 12, 31);
        setStage(1);
        setChar(996, 1000, 288, 380);
        frame(0);
        check("d32_req", bus.trans_req, 1);
        check("d32_stage", bus.newStageCode, 2);
        check("d32_posx", bus.real_new_posX, 32);
        check("d32_idx", bus.hit_idx, 0);
        ackReq(2);

        // Door drawing
        drawCheck("d34_in", 928, 320, 64, 0);
        check("d34_in_const", drawAny, 1);
        drawCheck("d34_below", 928, 384, 64, 0);
        check("d34_below_const", drawAny, 0);
        rom[1][0] = mk(1, 1, 2, 0, 12, 31);
        frame(0);
        drawCheck("d34_h0", 928, 320, 64, 0);
        check("d34_h0_const", drawAny, 0);
        rom[1][0] = mk(1, 1, 2, 4, 12, 31);
        frame(1);
        drawCheck("d34_restored", 928, 320, 64, 0);

        // Stage switch in the middle of a scan
        predict(2, 2 * DOORS + 5, e);
        expQ.push_back(e);
        pulseFrame();
        n = 0;
        while (bus.rom_addr != 7'd6 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("d35_reach_idx2", bus.rom_addr, 7'd6);
        stageCode = 5'd2;
        mdlValid = 0;
        @(posedge clk);
        #1 check("d35_rom_addr", bus.rom_addr, 7'd8);
        waitSb();
        loadCacheModel(2);
        drawCheck("d35_no_draw", 928, 320, 64, 0);
        check("d35_no_draw_const", drawAny, 0);

        // Overlapping doors, long ack hold and cooldown length
        rom[3][0] = mk(1, 3, 4, 3, 10, 20);
        rom[3][1] = mk(1, 9, 7, 3, 10, 5);
        rom[3][2] = mk(0, 0, 0, 0, 0, 0);
        rom[3][3] = mk(1, 4, 8, 5, 10, 5);
        setStage(3);
        setChar(165, 170, 260, 300);
        drain();
        frame(0);
        check("d33_idx", bus.hit_idx, 1);
        ackReq(50);
        for (int k = 0; k < COOLDOWN; k++) frame(0);
        frame(0);
        check("d33_31st_req", bus.trans_req, 1);
        check("d33_31st_idx", bus.hit_idx, 1);
        ackReq(0);

        // Reset during a pending request
        drain();
        CounterX = 16'd170; CounterY = 16'd270; stage_posX = '0; stage_posY = '0;
        frame(0);
        check("d36_pre_draw", drawAny, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("d36_req_async", bus.trans_req, 0);
        check("d36_draw_async", drawAny, 0);
        check("d36_idx_rst", bus.hit_idx, 0);
        modelCool = 0;
        mdlValid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drawCheck("d36_cache_empty", 170, 270, 0, 0);
        check("d36_cache_empty_const", drawAny, 0);
        // Reset during a scan
        pulseFrame();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("d31_no_req", bus.trans_req, 0);
        repeat (2) @(posedge clk);
        #1;
        frame(0);
        check("d31_fresh_req", bus.trans_req, 1);
        ackReq(1);

        // Randomized stages, doors, hitboxes and pixels
        for (int it = 0; it < 40; it++) begin
            st = (it % 3 == 0) ? int'($urandom_range(4, 31)) : int'(stageCode);
            setStage(st);
            for (int i = 0; i < DOORS; i++)
                rom[st][i] = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom_range(0, 6),
                                $urandom_range(1, 31), $urandom_range(0, 31));
            t = $urandom_range(0, DOORS - 1);
            x = int'(rom[st][t][4:0]);
            y = int'(rom[st][t][9:5]);
            h = int'(rom[st][t][14:10]);
            lo = (y >= h) ? y - h : 0;
            if ($urandom_range(0, 3) != 0 && h != 0) begin
                wx = x * 32 + $urandom_range(0, 15);
                wy = lo * 32 + $urandom_range(0, 10);
                setChar(wx, wx + $urandom_range(0, 15), wy, wy + $urandom_range(0, 20));
            end else begin
                wx = $urandom_range(0, 1000);
                wy = $urandom_range(0, 1000);
                setChar(wx, wx + $urandom_range(0, 40), wy, wy + $urandom_range(0, 40));
            end
            frame($urandom_range(0, 3) == 0);
            if (lastExp.req) begin
                ackReq($urandom_range(0, 4));
                if ($urandom_range(0, 1) == 0) drain();
            end
            for (int k = 0; k < 3; k++) begin
                t = $urandom_range(0, DOORS - 1);
                x = int'(mdlCache[t][4:0]);
                y = int'(mdlCache[t][9:5]);
                h = int'(mdlCache[t][14:10]);
                lo = (y >= h) ? y - h : 0;
                ty = $urandom_range((lo > 0) ? lo - 1 : 0, y);
                wx = x * 32 + $urandom_range(0, 31);
                wy = ty * 32 + $urandom_range(0, 31);
                px = $urandom_range(0, 65535);
                py = $urandom_range(0, 65535);
                drawCheck("rnd_draw", (wx - px) & 32'hFFFF, (wy - py) & 32'hFFFF, px, py);
            end
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
